// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, data-memory wait and redirect flushes.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int FC_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0;
    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam bit TO_EN   = (MEM_TIMEOUT > 0);

    state_t            state_r;
    logic [FC_W-1:0]   flush_cnt_r;
    logic              pend_redir_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic freeze_s;
    logic redirect_s;
    logic flushing_s;
    logic load_use_raw_s;
    logic load_use_s;
    logic timeout_hit_s;

    // Hazard detection and priority resolution: freeze > redirect > flush countdown > load-use
    always_comb begin
        freeze_s       = dmem_req & ~dmem_ready;
        redirect_s     = ~freeze_s & (ex_redirect | pend_redir_r);
        // A non-zero countdown also covers a flush that was paused by a freeze
        flushing_s     = ~freeze_s & ~redirect_s & (flush_cnt_r != {FC_W{1'b0}});
        load_use_raw_s = ex_MemRead & (ex_rd_addr != 5'd0) &
                         ((id_use_rs1 & (ex_rd_addr == id_rs1_addr)) |
                          (id_use_rs2 & (ex_rd_addr == id_rs2_addr)));
        load_use_s     = load_use_raw_s & ~freeze_s & ~redirect_s & ~flushing_s &
                         (state_r != ST_FLUSH);
        timeout_hit_s  = TO_EN & freeze_s & (wait_cnt_r == WAIT_W'(TO_LAST));
    end

    // Pipeline control outputs; reset holds both flushes so the pipe fills with NOPs
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze_s) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
            mem_timeout  = timeout_hit_s;
        end else if (redirect_s) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (flushing_s) begin
            ifid_flush = 1'b1;
        end else if (load_use_s) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else begin
            mem_timeout = 1'b0;
        end
    end

    // FSM with flush countdown, deferred redirect and consecutive-wait timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            flush_cnt_r  <= {FC_W{1'b0}};
            pend_redir_r <= 1'b0;
            wait_cnt_r   <= {WAIT_W{1'b0}};
        end else if (freeze_s) begin
            state_r      <= ST_MEM_WAIT;
            pend_redir_r <= pend_redir_r | ex_redirect;
            wait_cnt_r   <= timeout_hit_s ? {WAIT_W{1'b0}} : wait_cnt_r + WAIT_W'(1);
        end else begin
            pend_redir_r <= 1'b0;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            if (redirect_s) begin
                flush_cnt_r <= FC_W'(FC_LOAD);
                state_r     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            end else if (flushing_s) begin
                flush_cnt_r <= flush_cnt_r - FC_W'(1);
                state_r     <= (flush_cnt_r == FC_W'(1)) ? ST_RUN : ST_FLUSH;
            end else begin
                flush_cnt_r <= {FC_W{1'b0}};
                state_r     <= ST_RUN;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] redir_cnt_r;

    // Performance counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            redir_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (freeze_s | load_use_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (redirect_s) begin
                redir_cnt_r <= redir_cnt_r + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = redir_cnt_r;
`else
    assign perf_stall_cnt = {CNT_W{1'b0}};
    assign perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, multi-cycle sequences and a randomized
// run against a cycle-level reference model, on two configurations driven by the same inputs.
module tb_pipeline_hazard_ctrl;

    localparam int FC_A = 3;
    localparam int MT_A = 4;
    localparam int CW_A = 16;
    localparam int FC_B = 1;
    localparam int MT_B = 64;
    localparam int CW_B = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // out bit order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble, mem_timeout
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_FRZ  = 8'b1101_0110;
    localparam logic [7:0] O_RD   = 8'b0010_1000;
    localparam logic [7:0] O_IFF  = 8'b0010_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       memread;
        logic [4:0] rd;
        logic       redir;
        logic       req;
        logic       ready;
    } vin_t;

    typedef struct {
        string      name;
        vin_t       v;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        bit     pend;
        int     flush_left;
        int     consec;
        longint stalls;
        longint flushes;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect, dmem_req, dmem_ready;

    logic pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a;
    logic exmem_stall_a, memwb_bubble_a, mem_timeout_a;
    logic [CW_A-1:0] perf_stall_a, perf_flush_a;
    logic pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b;
    logic exmem_stall_b, memwb_bubble_b, mem_timeout_b;
    logic [CW_B-1:0] perf_stall_b, perf_flush_b;
    logic [7:0] out_a, out_b;

    assign out_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a,
                    exmem_stall_a, memwb_bubble_a, mem_timeout_a};
    assign out_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b,
                    exmem_stall_b, memwb_bubble_b, mem_timeout_b};

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC_A), .MEM_TIMEOUT(MT_A), .CNT_W(CW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_MemRead(ex_MemRead), .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a),
        .idex_stall(idex_stall_a), .idex_flush(idex_flush_a), .exmem_stall(exmem_stall_a),
        .memwb_bubble(memwb_bubble_a), .mem_timeout(mem_timeout_a),
        .perf_stall_cnt(perf_stall_a), .perf_flush_cnt(perf_flush_a)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC_B), .MEM_TIMEOUT(MT_B), .CNT_W(CW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_MemRead(ex_MemRead), .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b),
        .idex_stall(idex_stall_b), .idex_flush(idex_flush_b), .exmem_stall(exmem_stall_b),
        .memwb_bubble(memwb_bubble_b), .mem_timeout(mem_timeout_b),
        .perf_stall_cnt(perf_stall_b), .perf_flush_cnt(perf_flush_b)
    );

    int checks = 0;
    int errors = 0;
    vec_t tab[$];

    function automatic vin_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                input bit mr, input int rd, input bit rdr, input bit rq, input bit ry);
        vin_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.use1 = u1; v.use2 = u2; v.memread = mr;
        v.rd = 5'(rd); v.redir = rdr; v.req = rq; v.ready = ry;
        return v;
    endfunction

    // Reference model: one clock cycle of the stall/flush rules
    function automatic void model_step(input mstate_t s, input vin_t v, input int fc, input int mt,
                                       output logic [7:0] o, output mstate_t ns);
        bit frz, lu;
        ns  = s;
        o   = O_NONE;
        frz = v.req && !v.ready;
        lu  = v.memread && (v.rd != 5'd0) &&
              ((v.use1 && v.rd == v.rs1) || (v.use2 && v.rd == v.rs2));
        if (frz) begin
            o = O_FRZ;
            ns.consec = s.consec + 1;
            if (mt != 0 && (ns.consec % mt) == 0) o[0] = 1'b1;
            if (v.redir) ns.pend = 1'b1;
            ns.stalls = s.stalls + 1;
        end else begin
            ns.consec = 0;
            ns.pend   = 1'b0;
            if (v.redir || s.pend) begin
                o = O_RD;
                ns.flush_left = fc - 1;
                ns.flushes = s.flushes + 1;
            end else if (s.flush_left > 0) begin
                o = O_IFF;
                ns.flush_left = s.flush_left - 1;
            end else if (lu) begin
                o = O_LU;
                ns.stalls = s.stalls + 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vin_t v);
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_MemRead = v.memread; ex_rd_addr = v.rd; ex_redirect = v.redir;
        dmem_req = v.req; dmem_ready = v.ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare both DUTs mid-cycle, then advance one clock
    task automatic step_chk(input string name, input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clk);
        chk({name, "_a"}, {24'd0, out_a}, {24'd0, ea});
        chk({name, "_b"}, {24'd0, out_b}, {24'd0, eb});
        tick();
    endtask

    task automatic chk_perf_zero(input string name);
        chk({name, "_pstall_a"}, {16'd0, perf_stall_a}, 32'd0);
        chk({name, "_pflush_a"}, {16'd0, perf_flush_a}, 32'd0);
        chk({name, "_pstall_b"}, {28'd0, perf_stall_b}, 32'd0);
        chk({name, "_pflush_b"}, {28'd0, perf_flush_b}, 32'd0);
    endtask

    // Asynchronous reset pulse inside a cycle; called just after a rising edge
    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        chk({name, "_rst_a"}, {24'd0, out_a}, {24'd0, O_RD});
        chk({name, "_rst_b"}, {24'd0, out_b}, {24'd0, O_RD});
        chk_perf_zero(name);
        rst_n = 1'b1;
    endtask

    vin_t v_idle, v_frz, v_frz_rd, v_rdy, v_lu, v_rd, v_rd_lu;
    mstate_t ma, mb, na, nb;
    logic [7:0] oa, ob;
    vin_t vr;
    int hold;

    initial begin
        v_idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_frz    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        v_frz_rd = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
        v_rdy    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        v_lu     = mk(5, 0, 1, 0, 1, 5, 0, 0, 0);
        v_rd     = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        v_rd_lu  = mk(5, 0, 1, 0, 1, 5, 1, 0, 0);

        tab.push_back('{"lu_rs1",     v_lu,                              O_LU});
        tab.push_back('{"lu_rs2",     mk(1, 7, 0, 1, 1, 7, 0, 0, 0),     O_LU});
        tab.push_back('{"x0_dest",    mk(0, 0, 1, 1, 1, 0, 0, 0, 0),     O_NONE});
        tab.push_back('{"unused_rs1", mk(5, 0, 0, 0, 1, 5, 0, 0, 0),     O_NONE});
        tab.push_back('{"not_load",   mk(5, 5, 1, 1, 0, 5, 0, 0, 0),     O_NONE});
        tab.push_back('{"no_match",   mk(6, 4, 1, 1, 1, 5, 0, 0, 0),     O_NONE});
        tab.push_back('{"freeze",     v_frz,                             O_FRZ});
        tab.push_back('{"req_ready",  v_rdy,                             O_NONE});
        tab.push_back('{"frz_lu",     mk(5, 0, 1, 0, 1, 5, 0, 1, 0),     O_FRZ});
        tab.push_back('{"redirect",   v_rd,                              O_RD});
        tab.push_back('{"redir_lu",   v_rd_lu,                           O_RD});
        tab.push_back('{"ready_only", mk(0, 0, 0, 0, 0, 0, 0, 0, 1),     O_NONE});

        // Outputs held during reset even with a freeze on the inputs
        rst_n = 1'b0;
        drive(v_frz);
        #12;
        chk("reset_a", {24'd0, out_a}, {24'd0, O_RD});
        chk("reset_b", {24'd0, out_b}, {24'd0, O_RD});
        chk_perf_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(v_idle);
        tick();

        foreach (tab[i]) begin
            drive(tab[i].v);
            step_chk(tab[i].name, tab[i].exp, tab[i].exp);
            drive(v_idle);
            repeat (4) tick();
        end

        // Load-use is counted once
        do_reset("t1");
        drive(v_lu);
        step_chk("t1_lu", O_LU, O_LU);
        drive(v_idle);
        @(negedge clk);
        chk("t1_pstall_a", {16'd0, perf_stall_a}, 32'(PERF_ON ? 1 : 0));
        chk("t1_pstall_b", {28'd0, perf_stall_b}, 32'(PERF_ON ? 1 : 0));
        tick();

        // Three-cycle memory wait
        for (int k = 0; k < 3; k++) begin
            drive(v_frz);
            step_chk("t3_frz", O_FRZ, O_FRZ);
        end
        drive(v_rdy);
        step_chk("t3_done", O_NONE, O_NONE);

        // Redirect arriving in the second freeze cycle is deferred
        drive(v_frz);    step_chk("t4_frz1", O_FRZ, O_FRZ);
        drive(v_frz_rd); step_chk("t4_frz2", O_FRZ, O_FRZ);
        drive(v_frz);    step_chk("t4_frz3", O_FRZ, O_FRZ);
        drive(v_idle);   step_chk("t4_apply", O_RD, O_RD);
        step_chk("t4_fl2", O_IFF, O_NONE);
        step_chk("t4_fl3", O_IFF, O_NONE);
        step_chk("t4_end", O_NONE, O_NONE);

        // Redirect with simultaneous load-use; load-use held on the following cycles
        drive(v_rd_lu); step_chk("t5_c1", O_RD, O_RD);
        drive(v_lu);    step_chk("t5_c2", O_IFF, O_LU);
        step_chk("t5_c3", O_IFF, O_LU);
        step_chk("t5_c4", O_LU, O_LU);
        drive(v_idle);
        tick();

        // Ten-cycle freeze: timeout pulses on cycles 4 and 8 of configuration A only
        for (int k = 1; k <= 10; k++) begin
            drive((k == 9) ? v_frz_rd : v_frz);
            step_chk($sformatf("t6_frz%0d", k), (k % 4 == 0) ? (O_FRZ | 8'h01) : O_FRZ, O_FRZ);
        end
        drive(v_frz);
        step_chk("t6_frz11", O_FRZ, O_FRZ);
        do_reset("t6");
        drive(v_idle);
        step_chk("t6_after_rst", O_NONE, O_NONE);
        for (int k = 1; k <= 5; k++) begin
            drive(v_frz);
            step_chk($sformatf("t6_refrz%0d", k), (k == 4) ? (O_FRZ | 8'h01) : O_FRZ, O_FRZ);
        end
        drive(v_rdy);
        step_chk("t6_ready", O_NONE, O_NONE);

        // Reset during a multi-cycle flush cancels the remaining flush cycles
        drive(v_rd);
        step_chk("rf_redir", O_RD, O_RD);
        do_reset("rf");
        drive(v_idle);
        step_chk("rf_after", O_NONE, O_NONE);

        // Randomized run against the reference model
        do_reset("rnd");
        ma = '{default: 0};
        mb = '{default: 0};
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            vr.rs1     = 5'($urandom_range(0, 3));
            vr.rs2     = 5'($urandom_range(0, 3));
            vr.rd      = 5'($urandom_range(0, 3));
            vr.use1    = 1'($urandom_range(0, 1));
            vr.use2    = 1'($urandom_range(0, 1));
            vr.memread = 1'($urandom_range(0, 1));
            vr.redir   = ($urandom_range(0, 7) == 0);
            if (hold == 0 && $urandom_range(0, 49) == 0) hold = $urandom_range(3, 12);
            if (hold > 0) begin
                vr.req = 1'b1; vr.ready = 1'b0; hold--;
            end else begin
                vr.req   = ($urandom_range(0, 3) == 0);
                vr.ready = 1'($urandom_range(0, 1));
            end
            drive(vr);
            @(negedge clk);
            model_step(ma, vr, FC_A, MT_A, oa, na);
            model_step(mb, vr, FC_B, MT_B, ob, nb);
            chk("rnd_out_a", {24'd0, out_a}, {24'd0, oa});
            chk("rnd_out_b", {24'd0, out_b}, {24'd0, ob});
            chk("rnd_pstall_a", {16'd0, perf_stall_a}, 32'(PERF_ON ? (ma.stalls % 65536) : 0));
            chk("rnd_pflush_a", {16'd0, perf_flush_a}, 32'(PERF_ON ? (ma.flushes % 65536) : 0));
            chk("rnd_pstall_b", {28'd0, perf_stall_b}, 32'(PERF_ON ? (mb.stalls % 16) : 0));
            chk("rnd_pflush_b", {28'd0, perf_flush_b}, 32'(PERF_ON ? (mb.flushes % 16) : 0));
            tick();
            ma = na;
            mb = nb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
